// File: rtl/ldpc_pkg.sv
// Shared LDPC definitions: default parity matrix, FSM states and the encode/syndrome helpers.
// Helpers work on max-width vectors so that any K/M up to MaxK/MaxM can reuse them.
package ldpc_pkg;

  localparam int unsigned KDef  = 4;
  localparam int unsigned NDef  = 12;
  localparam int unsigned MDef  = NDef - KDef;
  localparam logic [MDef*KDef-1:0] HpDef = 32'hE7A59C63;

  localparam int unsigned MaxK  = 16;
  localparam int unsigned MaxM  = 32;
  localparam int unsigned MaxHp = MaxK * MaxM;

  typedef enum logic [1:0] {StIdle, StDec, StDone} state_e;

  // Parity bit j is the XOR of the message bits selected by row j of P.
  function automatic logic [MaxM-1:0] ldpc_enc(input logic [MaxK-1:0]  msg,
                                               input logic [MaxHp-1:0] h_p,
                                               input int unsigned      k,
                                               input int unsigned      m);
    logic [MaxM-1:0] par;
    par = '0;
    for (int unsigned j = 0; j < MaxM; j++) begin
      for (int unsigned i = 0; i < MaxK; i++) begin
        if (j < m && i < k) par[j] = par[j] ^ (h_p[j*k + i] & msg[i]);
      end
    end
    return par;
  endfunction

  function automatic logic [MaxM-1:0] ldpc_syn(input logic [MaxK-1:0]  msg,
                                               input logic [MaxM-1:0]  par,
                                               input logic [MaxHp-1:0] h_p,
                                               input int unsigned      k,
                                               input int unsigned      m);
    return ldpc_enc(msg, h_p, k, m) ^ par;
  endfunction

  // Parity columns of [P | I] always have weight 1, so the floor is 1.
  function automatic int unsigned ldpc_max_colw(input logic [MaxHp-1:0] h_p,
                                                input int unsigned      k,
                                                input int unsigned      m);
    int unsigned best;
    int unsigned w;
    best = 1;
    for (int unsigned i = 0; i < MaxK; i++) begin
      w = 0;
      for (int unsigned j = 0; j < MaxM; j++) begin
        if (j < m && i < k && h_p[j*k + i]) w++;
      end
      if (w > best) best = w;
    end
    return best;
  endfunction

  localparam int unsigned CW = $clog2(ldpc_max_colw(MaxHp'(HpDef), KDef, MDef) + 1);

endpackage

// File: rtl/ldpc_bitflip_core.sv
// Combinational single-iteration hard-decision bit-flip step over one received word.
module ldpc_bitflip_core
  import ldpc_pkg::*;
#(
  parameter  int unsigned K    = KDef,
  parameter  int unsigned N    = NDef,
  parameter  int unsigned CntW = CW,
  localparam int unsigned M    = N - K,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    i_word,
  input  logic [M*K-1:0]  i_h_p,
  output logic [M-1:0]    o_syndrome,
  output logic            o_syn_zero,
  output logic [IdxW-1:0] o_flip_idx,
  output logic [N-1:0]    o_word
);

  always_comb begin
    logic [M-1:0]    syn;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] best;
    syn        = M'(ldpc_syn(MaxK'(i_word[N-1:M]), MaxM'(i_word[M-1:0]), MaxHp'(i_h_p), K, M));
    best       = '0;
    cnt        = '0;
    o_flip_idx = '0;
    // Strict '>' keeps the lowest index on ties.
    for (int unsigned b = 0; b < N; b++) begin
      cnt = '0;
      for (int unsigned j = 0; j < M; j++) begin
        if (b >= M) begin
          if (syn[j] && i_h_p[j*K + b - M]) cnt = cnt + CntW'(1);
        end else if (b == j && syn[j]) begin
          cnt = cnt + CntW'(1);
        end
      end
      if (cnt > best) begin
        best       = cnt;
        o_flip_idx = IdxW'(b);
      end
    end
    o_syndrome = syn;
    o_syn_zero = (syn == '0);
    o_word     = i_word ^ (N'(!o_syn_zero) << o_flip_idx);
  end

endmodule

// File: rtl/ldpc_codec_stream.sv
// Streaming LDPC encode -> error-mask channel -> bit-flip decode with valid/ready handshakes.
module ldpc_codec_stream
  import ldpc_pkg::*;
#(
  parameter  int unsigned         K        = KDef,
  parameter  int unsigned         N        = NDef,
  parameter  logic [(N-K)*K-1:0]  H_P      = HpDef,
  parameter  int unsigned         MAX_ITER = 8,
  localparam int unsigned         M        = N - K,
  localparam int unsigned         IW       = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [K-1:0]  msg,
  input  logic [N-1:0]  err_mask,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  code,
  output logic [N-1:0]  rx_code,
  output logic [K-1:0]  re_msg,
  output logic          dec_ok,
  output logic [IW-1:0] dec_iter
);

  localparam int unsigned CntW = $clog2(ldpc_max_colw(MaxHp'(H_P), K, M) + 1);

  state_e          r_state, w_state_d;
  logic [N-1:0]    r_code, w_code_d;
  logic [N-1:0]    r_rx, w_rx_d;
  logic [N-1:0]    r_word, w_word_d;
  logic [IW-1:0]   r_iter, w_iter_d;
  logic            r_ok, w_ok_d;

  logic [M-1:0]          w_enc_par;
  logic [N-1:0]          w_enc_code;
  logic [N-1:0]          w_core_word;
  logic                  w_syn_zero;
  logic [M-1:0]          w_unused_syn;
  logic [$clog2(N)-1:0]  w_unused_flip_idx;

  assign w_enc_par  = M'(ldpc_enc(MaxK'(msg), MaxHp'(H_P), K, M));
  assign w_enc_code = {msg, w_enc_par};

  ldpc_bitflip_core #(
    .K    (K),
    .N    (N),
    .CntW (CntW)
  ) u_core (
    .i_word     (r_word),
    .i_h_p      (H_P),
    .o_syndrome (w_unused_syn),
    .o_syn_zero (w_syn_zero),
    .o_flip_idx (w_unused_flip_idx),
    .o_word     (w_core_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_code  <= '0;
      r_rx    <= '0;
      r_word  <= '0;
      r_iter  <= '0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_code  <= w_code_d;
      r_rx    <= w_rx_d;
      r_word  <= w_word_d;
      r_iter  <= w_iter_d;
      r_ok    <= w_ok_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_code_d  = r_code;
    w_rx_d    = r_rx;
    w_word_d  = r_word;
    w_iter_d  = r_iter;
    w_ok_d    = r_ok;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_code_d  = w_enc_code;
          w_rx_d    = w_enc_code ^ err_mask;
          w_word_d  = w_enc_code ^ err_mask;
          w_iter_d  = '0;
          w_ok_d    = 1'b0;
          w_state_d = StDec;
        end
      end
      StDec: begin
        if (w_syn_zero) begin
          w_ok_d    = 1'b1;
          w_state_d = StDone;
        end else if (r_iter == IW'(MAX_ITER)) begin
          w_ok_d    = 1'b0;
          w_state_d = StDone;
        end else begin
          w_word_d = w_core_word;
          w_iter_d = r_iter + IW'(1);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign code     = r_code;
  assign rx_code  = r_rx;
  assign re_msg   = r_word[N-1:M];
  assign dec_ok   = r_ok;
  assign dec_iter = r_iter;

endmodule

// File: tb/tb_ldpc_codec_stream.sv
// Directed self-checking bench: default decoder plus a MAX_ITER=1 instance.
module tb_ldpc_codec_stream;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, dec_ok;
  logic [3:0]  msg, re_msg, dec_iter;
  logic [11:0] err_mask, code, rx_code;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_dec_ok;
  logic [3:0]  b_msg, b_re_msg;
  logic [0:0]  b_dec_iter;
  logic [11:0] b_err_mask, b_code, b_rx_code;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  ldpc_codec_stream u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .msg       (msg),
    .err_mask  (err_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code      (code),
    .rx_code   (rx_code),
    .re_msg    (re_msg),
    .dec_ok    (dec_ok),
    .dec_iter  (dec_iter)
  );

  ldpc_codec_stream #(
    .MAX_ITER (1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .msg       (b_msg),
    .err_mask  (b_err_mask),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .code      (b_code),
    .rx_code   (b_rx_code),
    .re_msg    (b_re_msg),
    .dec_ok    (b_dec_ok),
    .dec_iter  (b_dec_iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles counted from the accepting cycle (cycle 0) to the first out_valid cycle.
  task automatic wait_out(output int cycles);
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic send(input logic [3:0] m, input logic [11:0] e, output int cycles);
    msg      = m;
    err_mask = e;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(cycles);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic check_result(input string tag, input logic [11:0] e_code, input logic [11:0] e_rx,
                              input logic [3:0] e_msg, input logic e_ok, input logic [3:0] e_iter,
                              input int e_lat, input int got_lat);
    chk({tag, "_lat"}, 32'(got_lat), 32'(e_lat));
    chk({tag, "_code"}, code, e_code);
    chk({tag, "_rx"}, rx_code, e_rx);
    chk({tag, "_re_msg"}, re_msg, e_msg);
    chk({tag, "_ok"}, dec_ok, e_ok);
    chk({tag, "_iter"}, dec_iter, e_iter);
    chk({tag, "_in_ready_done"}, in_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; msg = '0; err_mask = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_msg = '0; b_err_mask = '0; b_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_code", code, 12'h000);
    chk("rst_rx", rx_code, 12'h000);
    chk("rst_re_msg", re_msg, 4'h0);
    chk("rst_iter", dec_iter, 4'h0);
    chk("rst_ok", dec_ok, 1'b0);

    // Clean word.
    send(4'hB, 12'h000, lat);
    check_result("t1", 12'hB16, 12'hB16, 4'hB, 1'b1, 4'd0, 2, lat);
    handshake("t1");

    // Message MSB error: one flip of bit 11.
    send(4'hB, 12'h800, lat);
    check_result("t2", 12'hB16, 12'h316, 4'hB, 1'b1, 4'd1, 3, lat);
    handshake("t2");

    // Parity bit 2 error: three-way tie resolved to the lowest index (bit 2).
    send(4'hB, 12'h004, lat);
    check_result("t3", 12'hB16, 12'hB12, 4'hB, 1'b1, 4'd1, 3, lat);
    handshake("t3");

    // MAX_ITER=1, double error: first flip hits bit 8, then iteration cap.
    b_msg = 4'h0; b_err_mask = 12'hC00; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("t4_lat", 32'(lat), 32'd3);
    chk("t4_code", b_code, 12'h000);
    chk("t4_rx", b_rx_code, 12'hC00);
    chk("t4_re_msg", b_re_msg, 4'hD);
    chk("t4_ok", b_dec_ok, 1'b0);
    chk("t4_iter", b_dec_iter, 1'b1);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("t4_hs_ov_low", b_out_valid, 1'b0);

    // Back-to-back with in_valid held and out_ready stalled for 5 cycles.
    msg = 4'h1; err_mask = 12'h000; in_valid = 1'b1;
    tick();
    msg = 4'h2;
    wait_out(lat);
    check_result("t5a", 12'h159, 12'h159, 4'h1, 1'b1, 4'd0, 2, lat);
    for (int i = 0; i < 5; i++) begin
      chk("t5_stall_in_ready", in_ready, 1'b0);
      chk("t5_stall_out_valid", out_valid, 1'b1);
      chk("t5_stall_re_msg", re_msg, 4'h1);
      tick();
    end
    handshake("t5a");
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check_result("t5b", 12'h2E3, 12'h2E3, 4'h2, 1'b1, 4'd0, 2, lat);
    handshake("t5b");

    // Reset in the middle of a decode.
    msg = 4'hB; err_mask = 12'h800; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t6_in_dec", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_code", code, 12'h000);
    chk("t6_rx", rx_code, 12'h000);
    chk("t6_re_msg", re_msg, 4'h0);
    chk("t6_iter", dec_iter, 4'h0);
    chk("t6_ok", dec_ok, 1'b0);
    tick();
    chk("t6_no_stale", out_valid, 1'b0);
    send(4'h6, 12'h001, lat);
    check_result("t6b", 12'h635, 12'h634, 4'h6, 1'b1, 4'd1, 3, lat);
    handshake("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
